// File: rtl/ram_sdpx_clr_pkg.sv
// Shared definitions for the clearable simple-dual-port RAM:
// FSM state encoding and the read-latency legality check.
package ram_sdpx_clr_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit lane_split_legal(input int unsigned data_len,
                                          input int unsigned byte_len);
    return (byte_len != 0) && ((data_len % byte_len) == 0);
  endfunction

endpackage

// File: rtl/ram_sdpx_core.sv
// Storage array: one lane-masked write port and one registered read port.
// Read returns the pre-write contents on a same-address collision.
module ram_sdpx_core
  import ram_sdpx_clr_pkg::*;
#(
  parameter  int CAddrLen = 10,
  parameter  int CDataLen = 32,
  parameter  int CByteLen = 8,
  localparam int CLaneCnt = CDataLen / CByteLen
) (
  input  logic                i_clk,
  input  logic                i_en,
  input  logic                i_wr_en,
  input  logic [CAddrLen-1:0] i_wr_addr,
  input  logic [CLaneCnt-1:0] i_wr_lane,
  input  logic [CDataLen-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [CAddrLen-1:0] i_rd_addr,
  output logic [CDataLen-1:0] o_rd_data
);

  logic [CDataLen-1:0] r_mem [2**CAddrLen];
  logic [CDataLen-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_wr_en) begin
        for (int unsigned l = 0; l < CLaneCnt; l++) begin
          if (i_wr_lane[l]) begin
            r_mem[i_wr_addr][l*CByteLen +: CByteLen] <= i_wr_data[l*CByteLen +: CByteLen];
          end
        end
      end
      if (i_rd_en) begin
        r_rd_data <= r_mem[i_rd_addr];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ram_sdpx_clr.sv
// Simple-dual-port RAM with lane-masked writes, write-to-read collision
// bypass, 1- or 2-cycle read pipeline and a full-memory clear sequencer.
module ram_sdpx_clr
  import ram_sdpx_clr_pkg::*;
#(
  parameter int CAddrLen    = 10,
  parameter int CDataLen    = 32,
  parameter int CByteLen    = 8,
  parameter int CRdLat      = 1,
  parameter bit CClrOnReset = 1'b1
) (
  input  logic                         AClkH,
  input  logic                         AResetH,
  input  logic                         AClkHEn,
  input  logic [CAddrLen-1:0]          AAddrWr,
  input  logic [CDataLen-1:0]          AMosi,
  input  logic                         AWrEn,
  input  logic [CDataLen/CByteLen-1:0] AWrMask,
  input  logic [CAddrLen-1:0]          AAddrRd,
  input  logic                         ARdEn,
  output logic [CDataLen-1:0]          AMiso,
  output logic                         ARdVld,
  input  logic                         AClrReq,
  output logic                         ABusy
);

  localparam int                  CLaneCnt  = CDataLen / CByteLen;
  localparam logic [CAddrLen-1:0] CLastAddr = '1;

  if (!rd_lat_legal(CRdLat)) begin : g_bad_lat
    $error("ram_sdpx_clr: CRdLat must be 1 or 2");
  end
  if (!lane_split_legal(CDataLen, CByteLen)) begin : g_bad_lanes
    $error("ram_sdpx_clr: CDataLen must be a multiple of CByteLen");
  end

  logic [0:0]          r_state;
  logic [CAddrLen-1:0] r_clr_cnt;
  logic                w_busy;
  logic                w_acc_wr;
  logic                w_acc_rd;

  assign w_busy   = (r_state == ST_CLEAR);
  assign w_acc_wr = AWrEn & ~w_busy;
  assign w_acc_rd = ARdEn & ~w_busy;
  assign ABusy    = w_busy;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_state   <= CClrOnReset ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else if (AClkHEn) begin
      case (r_state)
        ST_IDLE: begin
          if (AClrReq) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == CLastAddr) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // While clearing, the sequencer owns the write port and user writes are dropped.
  logic                w_mem_wr_en;
  logic [CAddrLen-1:0] w_mem_wr_addr;
  logic [CLaneCnt-1:0] w_mem_wr_lane;
  logic [CDataLen-1:0] w_mem_wr_data;
  logic [CDataLen-1:0] w_core_rd;

  always_comb begin
    w_mem_wr_en   = w_acc_wr;
    w_mem_wr_addr = AAddrWr;
    w_mem_wr_lane = AWrMask;
    w_mem_wr_data = AMosi;
    if (w_busy) begin
      w_mem_wr_en   = 1'b1;
      w_mem_wr_addr = r_clr_cnt;
      w_mem_wr_lane = '1;
      w_mem_wr_data = '0;
    end
  end

  ram_sdpx_core #(
    .CAddrLen (CAddrLen),
    .CDataLen (CDataLen),
    .CByteLen (CByteLen)
  ) u_core (
    .i_clk     (AClkH),
    .i_en      (AClkHEn),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_addr (w_mem_wr_addr),
    .i_wr_lane (w_mem_wr_lane),
    .i_wr_data (w_mem_wr_data),
    .i_rd_en   (w_acc_rd),
    .i_rd_addr (AAddrRd),
    .o_rd_data (w_core_rd)
  );

  logic                r_vld1;
  logic                r_byp_hit;
  logic [CLaneCnt-1:0] r_byp_lane;
  logic [CDataLen-1:0] r_byp_data;
  logic [CDataLen-1:0] w_rd_merged;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_vld1    <= 1'b0;
      r_byp_hit <= 1'b0;
    end else if (AClkHEn) begin
      r_vld1    <= w_acc_rd;
      r_byp_hit <= w_acc_rd & w_acc_wr & (AAddrRd == AAddrWr);
    end
  end

  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      r_byp_lane <= AWrMask;
      r_byp_data <= AMosi;
    end
  end

  // The core returns old data on a collision; overlay the lanes just written.
  always_comb begin
    w_rd_merged = w_core_rd;
    if (r_byp_hit) begin
      for (int unsigned l = 0; l < CLaneCnt; l++) begin
        if (r_byp_lane[l]) begin
          w_rd_merged[l*CByteLen +: CByteLen] = r_byp_data[l*CByteLen +: CByteLen];
        end
      end
    end
  end

  if (CRdLat == 2) begin : g_lat2
    logic                r_vld2;
    logic [CDataLen-1:0] r_data2;

    always_ff @(posedge AClkH) begin
      if (AResetH) begin
        r_vld2  <= 1'b0;
        r_data2 <= '0;
      end else if (AClkHEn) begin
        r_vld2  <= r_vld1;
        r_data2 <= r_vld1 ? w_rd_merged : '0;
      end
    end

    assign ARdVld = r_vld2;
    assign AMiso  = r_data2;
  end else begin : g_lat1
    assign ARdVld = r_vld1;
    assign AMiso  = r_vld1 ? w_rd_merged : '0;
  end

endmodule

// File: doc/ram_sdpx_clr.md
RAM_SDPX_CLR -- requirements
Module: ram_sdpx_clr

Interface
REQ-001 SHALL have parameter CAddrLen, default 10, address width; depth is 2**CAddrLen words.
REQ-002 SHALL have parameter CDataLen, default 32, word width.
REQ-003 SHALL have parameter CByteLen, default 8, lane width; CDataLen SHALL be a multiple of CByteLen, with CLaneCnt=CDataLen/CByteLen.
REQ-004 SHALL have parameter CRdLat, default 1, read latency in enabled cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter CClrOnReset, default 1; when 1, reset starts a memory clear.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 AClkH  in  1  sole clock; all state changes on its rising edge.
REQ-008 AResetH  in  1  synchronous active-high reset.
REQ-009 AClkHEn  in  1  clock enable; when 0, all state, pipeline and memory hold.
REQ-010 AAddrWr  in  CAddrLen  write address.
REQ-011 AMosi  in  CDataLen  write data.
REQ-012 AWrEn  in  1  write strobe.
REQ-013 AWrMask  in  CLaneCnt  per-lane write enable; bit i covers AMosi[i*CByteLen +: CByteLen].
REQ-014 AAddrRd  in  CAddrLen  read address.
REQ-015 ARdEn  in  1  read strobe.
REQ-016 AMiso  out  CDataLen  read data; forced to zero whenever ARdVld=0.
REQ-017 ARdVld  out  1  high exactly for the cycles in which AMiso carries read data.
REQ-018 AClrReq  in  1  request to zero the whole memory.
REQ-019 ABusy  out  1  high while a clear is in progress.

Function
REQ-020 An accepted write (AClkHEn=1, AWrEn=1, ABusy=0) SHALL update only the lanes whose AWrMask bit is set; all other lanes keep their values.
REQ-021 An accepted read (AClkHEn=1, ARdEn=1, ABusy=0) SHALL produce ARdVld=1 and the data CRdLat enabled cycles later.
REQ-022 If a read and a write hit the same address in the same cycle, the read SHALL return the merged new word: masked lanes from AMosi, unmasked lanes from the old memory contents.
REQ-023 The read pipeline SHALL carry the valid flag alongside the data; with back-to-back reads it SHALL deliver one result per enabled cycle.
REQ-024 The FSM SHALL have two states, IDLE and CLEAR; ABusy=1 exactly when the state is CLEAR.
REQ-025 IDLE->CLEAR SHALL occur on AClrReq=1 while AClkHEn=1; on entry the clear counter is set to 0.
REQ-026 In CLEAR, each enabled cycle SHALL write zero to all lanes at the counter address, then increment the counter.
REQ-027 CLEAR->IDLE SHALL occur on the cycle that writes address 2**CAddrLen-1; a clear takes exactly 2**CAddrLen enabled cycles.
REQ-028 In CLEAR, user writes and reads SHALL be dropped: no memory change and no ARdVld.
REQ-029 AClrReq asserted during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-030 Reads already in the pipeline when a clear starts SHALL complete with their pre-clear data.
REQ-031 With AClkHEn=0, ARdVld and AMiso SHALL hold their last values.

Reset
REQ-032 Reset SHALL clear ARdVld, the read pipeline and AMiso to 0.
REQ-033 Reset SHALL set the clear counter to 0, and the state to CLEAR if CClrOnReset=1, otherwise to IDLE.
REQ-034 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-035 Reset SHALL NOT alter memory contents directly; only the clear sequence zeroes memory.

Structure
REQ-036 The FSM state encoding and the CRdLat legality check SHALL live in the shared memory package.
REQ-037 The storage array SHALL be one sub-module, ram_sdpx_core: one write port with per-lane enables and one registered read port, inferable as block RAM.
REQ-038 Collision bypass, read pipeline and clear FSM SHALL sit in ram_sdpx_clr.

Verification
All scenarios use CAddrLen=4, CDataLen=32, CByteLen=8 and CRdLat=1 unless stated otherwise.
REQ-039 Release reset -> ABusy=1 for exactly 16 enabled cycles; then a read of address 5 -> AMiso=0x00000000 with ARdVld=1 one cycle later.
REQ-040 Write 0xDEADBEEF to address 3 with mask 4'b1111, then 0x000000AA with mask 4'b0001 -> a read of address 3 returns 0xDEADBEAA.
REQ-041 Address 7 holds 0x11223344; in one cycle, write 0xAABBCCDD mask 4'b1100 and read address 7 -> AMiso=0xAABB3344.
REQ-042 Issue a read, then drive AClkHEn=0 for 3 cycles -> ARdVld/AMiso frozen; on re-enable, sequencing resumes without loss or duplication.
REQ-043 Write 0x55 to address 2, pulse AClrReq, write 0x99 to address 2 during the clear -> ABusy high for 16 cycles; a read of address 2 afterwards returns 0.
REQ-044 CRdLat=2, reset asserted at clear counter 9 -> clear restarts and ABusy lasts a further 16 cycles; subsequent reads return data 2 cycles after ARdEn.
